dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares one synchronous single-port data RAM (1-cycle read latency) between the CPU data port and a host/DMA port. It also generates the CPU `stall` input. It converts the CPU's combinational-read memory model into RAM accesses: one stall cycle per read. It grants the host single-cycle slots without starving the CPU. It sits between the `cpu` data pins and the data RAM.

## Interface
Parameters:
- ADDR_WIDTH, 15, data address width (CPU `data_addr`, host address, RAM address).
- DATA_WIDTH, 16, data word width.

Ports:
- clk  in  1  clock.
- resetN  in  1  reset, synchronous, active-low.
- cpu_data_addr  in  ADDR_WIDTH  CPU data address.
- cpu_read_m  in  1  CPU read request. Does not depend on stall.
- cpu_write_m  in  1  CPU write strobe. Already gated by stall inside the CPU.
- cpu_out_m  in  DATA_WIDTH  CPU write data.
- cpu_in_m  out  DATA_WIDTH  read data to CPU.
- cpu_stall  out  1  stall to CPU.
- host_req  in  1  host access request. Must stay high, with address/data/we stable, until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_ack  out  1  one-cycle pulse: host access performed this cycle.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid (read only).
- host_rdata  out  DATA_WIDTH  host read data.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data; registered, valid the cycle after its address.

## Operation
- FSM with 3 states: IDLE, CPU_RD, HOST. State, host_rvalid and host_rd_pend are registered. All other outputs are combinational from state and inputs.
- `cpu_stall` is a function of state and `cpu_read_m` only. It never depends on `cpu_write_m`; the CPU gates write_m with stall, so any such dependency would form a combinational loop.
- IDLE (CPU owns the port):
  - ram_addr=cpu_data_addr, ram_wdata=cpu_out_m.
  - If cpu_read_m: ram_we=0, cpu_stall=1, next CPU_RD.
  - Else: ram_we=cpu_write_m, cpu_stall=0, next = host_req ? HOST : IDLE.
- CPU_RD (read data return; CPU executes its instruction):
  - cpu_stall=0.
  - ram_addr=cpu_data_addr, ram_we=cpu_write_m. This covers read-modify-write such as M=M+1.
  - Next = host_req ? HOST : IDLE.
- HOST:
  - cpu_stall=1, host_ack=1.
  - ram_addr=host_addr, ram_we=host_we, ram_wdata=host_wdata.
  - Next IDLE, unconditionally. The CPU always gets at least one cycle between host slots, so back-to-back host slots are impossible.
- cpu_in_m = ram_rdata at all times. It is meaningful only in CPU_RD.
- host_rdata = ram_rdata. host_rvalid is registered as (state==HOST && !host_we), so it is high the cycle after the slot.
- A host request arriving during a CPU read waits until CPU_RD has completed. A CPU read arriving in the cycle of host_rvalid is issued normally; no conflict, because the RAM output register already holds the host data.
- cpu_read_m during HOST is ignored; it is re-evaluated in the following IDLE.
- Reset outputs: state=IDLE, cpu_stall=0, host_ack=0, host_rvalid=0, ram_we=cpu_write_m (CPU port selected), host_rdata/cpu_in_m=ram_rdata.
- Reset mid-operation: an in-flight CPU_RD or HOST is abandoned. No host_rvalid follows. The host must re-request, as its host_ack may already have been given.

## Timing
- CPU read: 2 cycles. Cycle N: stall=1 and address issued. Cycle N+1: data on cpu_in_m, stall=0, the CPU consumes it.
- CPU write: 1 cycle, no stall, when not in HOST.
- Host access: ack at the earliest 1 cycle after host_req is first sampled high in IDLE/CPU_RD. Read data arrives the cycle after ack.
- Worst-case host wait: 2 cycles (IDLE with CPU read → CPU_RD → HOST).
- Worst-case CPU penalty per host slot: 1 stall cycle.

## Configuration
- `DMEM_ARB_PERF_EN` defined:
  - Adds outputs perf_stall_cnt (16 bits, counts cycles with cpu_stall=1) and perf_host_cnt (16 bits, counts host_ack pulses).
  - Both counters saturate at 16'hFFFF and clear only on reset.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
- Set RAM[0x0010]=16'h1234. Hold cpu_read_m=1, addr 0x0010, for one IDLE cycle → cpu_stall=1 in cycle N. In N+1: cpu_stall=0 and cpu_in_m=16'h1234.
- CPU write addr 0x0020, data 16'hBEEF, in IDLE → ram_we=1 the same cycle with no stall. A subsequent read of 0x0020 returns 16'hBEEF.
- Hold host_req high for a read of 0x0010 continuously while the CPU is idle → slots alternate IDLE/HOST. host_ack appears every 2nd cycle; host_rvalid follows each ack with 16'h1234. cpu_stall=1 only in HOST cycles.
- CPU read of 0x0010 and host write of 0x0030=16'h00AA both requested in the same IDLE cycle → sequence CPU_RD → HOST. cpu_in_m=16'h1234; host_ack falls in cycle N+2; RAM[0x0030]=16'h00AA.
- In CPU_RD, CPU writes read-data+1 to 0x0010 → RAM[0x0010]=16'h1235 with no extra stall.
- Assert resetN=0 during HOST → next cycle: IDLE, host_rvalid=0, cpu_stall=0. With DMEM_ARB_PERF_EN, the counters read 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU data port, host/DMA port and RAM port of the data-memory arbiter.
// The arbiter uses the slave modport; the surrounding CPU/host/RAM environment uses master.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] cpu_data_addr;
  logic                  cpu_read_m;
  logic                  cpu_write_m;
  logic [DATA_WIDTH-1:0] cpu_out_m;
  logic [DATA_WIDTH-1:0] cpu_in_m;
  logic                  cpu_stall;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  cpu_data_addr, cpu_read_m, cpu_write_m, cpu_out_m,
    output cpu_in_m, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rvalid, host_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_data_addr, cpu_read_m, cpu_write_m, cpu_out_m,
    input  cpu_in_m, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rvalid, host_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a 1-cycle-latency single-port data RAM between the CPU data port and a host/DMA port.
// Optional DMEM_ARB_PERF_EN adds saturating stall-cycle and host-slot counters.
//
// state  | meaning
// IDLE   | CPU owns the port; a CPU read is issued here with a stall
// CPU_RD | read data returns to the CPU, which may also write (read-modify-write)
// HOST   | single host slot; CPU stalled
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic clk,
  input  logic resetN,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_host_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    HOST   = 2'd2
  } state_t;

  state_t state;
  logic   host_rd_pend;

  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic                  we_mux;
  logic                  stall;
  logic                  ack;

  // Stall is derived from state and cpu_read_m only: the CPU gates write_m with stall.
  always_comb begin
    addr_mux  = bus.cpu_data_addr;
    wdata_mux = bus.cpu_out_m;
    we_mux    = bus.cpu_write_m;
    stall     = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_read_m) begin
          we_mux = 1'b0;
          stall  = 1'b1;
        end
      end
      CPU_RD: begin
        stall = 1'b0;
      end
      HOST: begin
        addr_mux  = bus.host_addr;
        wdata_mux = bus.host_wdata;
        we_mux    = bus.host_we;
        stall     = 1'b1;
        ack       = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= IDLE;
      host_rd_pend <= 1'b0;
    end else begin
      host_rd_pend <= (state == HOST) && !bus.host_we;
      case (state)
        IDLE: begin
          if (bus.cpu_read_m)     state <= CPU_RD;
          else if (bus.host_req)  state <= HOST;
          else                    state <= IDLE;
        end
        CPU_RD:  state <= bus.host_req ? HOST : IDLE;
        HOST:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr    = addr_mux;
  assign bus.ram_wdata   = wdata_mux;
  assign bus.ram_we      = we_mux;
  assign bus.cpu_stall   = stall;
  assign bus.host_ack    = ack;
  assign bus.host_rvalid = host_rd_pend;
  assign bus.cpu_in_m    = bus.ram_rdata;
  assign bus.host_rdata  = bus.ram_rdata;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      perf_stall_cnt <= 16'd0;
      perf_host_cnt  <= 16'd0;
    end else begin
      if (stall && (perf_stall_cnt != 16'hFFFF)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (ack && (perf_host_cnt != 16'hFFFF))    perf_host_cnt  <= perf_host_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random CPU/host traffic
// checked every cycle against a cycle-event model of port ownership and a shadow copy of the RAM.
module tb_dmem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk;
  logic resetN;
  int   n_tests = 0;
  int   n_fail  = 0;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_host_cnt;
`endif

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_host_cnt  (perf_host_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM: registered read of the old contents, write in the same edge
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] rd_tmp;
  always @(posedge clk) begin
    rd_tmp = ram[bus.ram_addr];
    if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
    bus.ram_rdata <= rd_tmp;
  end

  // Model: per-cycle events. A CPU read is "issued" in a cycle the port is free and not returning data;
  // its data returns the next cycle. A host slot follows a cycle that saw host_req and was neither
  // a host slot nor a read issue.
  bit            model_ok = 0;
  bit            m_host_next = 0;
  bit            m_ret_next = 0;
  bit            m_rvalid_next = 0;
  logic [DW-1:0] m_ret_data;
  logic [DW-1:0] m_hrd_data;
  int            m_stall_cnt = 0;
  int            m_host_cnt = 0;

  always @(negedge clk) begin
    bit            host_now, ret_now, issue_now, exp_stall, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    if (model_ok) begin
      host_now  = m_host_next;
      ret_now   = m_ret_next;
      issue_now = !host_now && !ret_now && bus.cpu_read_m;
      exp_stall = host_now || issue_now;
      exp_we    = host_now ? bus.host_we : (issue_now ? 1'b0 : bus.cpu_write_m);
      exp_addr  = host_now ? bus.host_addr : bus.cpu_data_addr;
      exp_wdata = host_now ? bus.host_wdata : bus.cpu_out_m;

      chk("stall", {31'd0, bus.cpu_stall}, {31'd0, exp_stall});
      chk("ack", {31'd0, bus.host_ack}, {31'd0, host_now});
      chk("rvalid", {31'd0, bus.host_rvalid}, {31'd0, m_rvalid_next});
      chk("ram_we", {31'd0, bus.ram_we}, {31'd0, exp_we});
      chk("ram_addr", {17'd0, bus.ram_addr}, {17'd0, exp_addr});
      if (exp_we) chk("ram_wdata", {16'd0, bus.ram_wdata}, {16'd0, exp_wdata});
      if (ret_now) chk("cpu_in_m", {16'd0, bus.cpu_in_m}, {16'd0, m_ret_data});
      if (m_rvalid_next) chk("host_rdata", {16'd0, bus.host_rdata}, {16'd0, m_hrd_data});
`ifdef DMEM_ARB_PERF_EN
      chk("perf_stall", {16'd0, perf_stall_cnt}, m_stall_cnt);
      chk("perf_host", {16'd0, perf_host_cnt}, m_host_cnt);
`endif
      if (issue_now) m_ret_data = shadow[bus.cpu_data_addr];
      if (host_now && !bus.host_we) m_hrd_data = shadow[bus.host_addr];
      if (exp_we) shadow[exp_addr] = exp_wdata;
      m_ret_next    = issue_now;
      m_rvalid_next = host_now && !bus.host_we;
      m_host_next   = bus.host_req && !host_now && !issue_now;
      if (exp_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (host_now && m_host_cnt < 65535) m_host_cnt++;
    end
    if (!resetN) begin
      model_ok      = 1;
      m_host_next   = 0;
      m_ret_next    = 0;
      m_rvalid_next = 0;
      m_stall_cnt   = 0;
      m_host_cnt    = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit host_busy;
  bit ack_seen;
  int host_wait;

  initial begin
    resetN            = 1'b0;
    bus.cpu_data_addr = '0;
    bus.cpu_read_m    = 1'b0;
    bus.cpu_write_m   = 1'b0;
    bus.cpu_out_m     = '0;
    bus.host_req      = 1'b0;
    bus.host_we       = 1'b0;
    bus.host_addr     = '0;
    bus.host_wdata    = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'h0000;
      shadow[i] = 16'h0000;
    end
    ram[15'h0010]    = 16'h1234;
    shadow[15'h0010] = 16'h1234;

    // reset state, CPU port selected
    repeat (2) @(posedge clk);
    #1;
    bus.cpu_write_m   = 1'b1;
    bus.cpu_data_addr = 15'h7FF0;
    bus.cpu_out_m     = 16'h5555;
    @(negedge clk);
    chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst_ack", {31'd0, bus.host_ack}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd1);

    // CPU read of 0x0010
    step();
    resetN = 1'b1;
    bus.cpu_write_m   = 1'b0;
    bus.cpu_read_m    = 1'b1;
    bus.cpu_data_addr = 15'h0010;
    @(negedge clk);
    chk("rd_stall_n", {31'd0, bus.cpu_stall}, 32'd1);
    step();
    @(negedge clk);
    chk("rd_stall_n1", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rd_data", {16'd0, bus.cpu_in_m}, 32'h1234);

    // CPU write 0x0020 then read back
    step();
    bus.cpu_read_m    = 1'b0;
    bus.cpu_write_m   = 1'b1;
    bus.cpu_data_addr = 15'h0020;
    bus.cpu_out_m     = 16'hBEEF;
    @(negedge clk);
    chk("wr_we", {31'd0, bus.ram_we}, 32'd1);
    chk("wr_stall", {31'd0, bus.cpu_stall}, 32'd0);
    step();
    bus.cpu_write_m = 1'b0;
    bus.cpu_read_m  = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("wr_readback", {16'd0, bus.cpu_in_m}, 32'hBEEF);

    // continuous host reads of 0x0010: IDLE/HOST alternate
    step();
    bus.cpu_read_m = 1'b0;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 15'h0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hloop_ack", {31'd0, bus.host_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("hloop_stall", {31'd0, bus.cpu_stall}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0 && i > 0) chk("hloop_rdata", {16'd0, bus.host_rdata}, 32'h1234);
      step();
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    chk("hloop_last_rvalid", {31'd0, bus.host_rvalid}, 32'd1);

    // CPU read and host write in the same IDLE cycle
    step();
    bus.cpu_read_m    = 1'b1;
    bus.cpu_data_addr = 15'h0010;
    bus.host_req      = 1'b1;
    bus.host_we       = 1'b1;
    bus.host_addr     = 15'h0030;
    bus.host_wdata    = 16'h00AA;
    @(negedge clk);
    chk("mix_n_ack", {31'd0, bus.host_ack}, 32'd0);
    step();
    @(negedge clk);
    chk("mix_n1_data", {16'd0, bus.cpu_in_m}, 32'h1234);
    chk("mix_n1_ack", {31'd0, bus.host_ack}, 32'd0);
    step();
    bus.cpu_read_m = 1'b0;
    @(negedge clk);
    chk("mix_n2_ack", {31'd0, bus.host_ack}, 32'd1);
    step();
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;
    chk("mix_ram30", {16'd0, ram[15'h0030]}, 32'h00AA);

    // read-modify-write in CPU_RD
    bus.cpu_read_m    = 1'b1;
    bus.cpu_data_addr = 15'h0010;
    @(negedge clk);
    step();
    bus.cpu_write_m = 1'b1;
    bus.cpu_out_m   = bus.cpu_in_m + 16'd1;
    @(negedge clk);
    chk("rmw_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rmw_we", {31'd0, bus.ram_we}, 32'd1);
    step();
    bus.cpu_read_m  = 1'b0;
    bus.cpu_write_m = 1'b0;
    chk("rmw_ram10", {16'd0, ram[15'h0010]}, 32'h1235);

    // reset during a host slot
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 15'h0010;
    @(negedge clk);
    step();
    resetN       = 1'b0;
    bus.host_req = 1'b0;
    @(negedge clk);
    chk("hrst_in_host", {31'd0, bus.host_ack}, 32'd1);
    step();
    resetN = 1'b1;
    @(negedge clk);
    chk("hrst_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    chk("hrst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("hrst_ack", {31'd0, bus.host_ack}, 32'd0);
`ifdef DMEM_ARB_PERF_EN
    chk("hrst_perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
    chk("hrst_perf_host", {16'd0, perf_host_cnt}, 32'd0);
`endif

    // random traffic
    host_busy = 0;
    ack_seen  = 0;
    host_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      resetN = ($urandom_range(0, 299) != 0);
      if (!resetN) begin
        host_busy    = 0;
        bus.host_req = 1'b0;
      end else if (host_busy && ack_seen) begin
        host_busy    = 0;
        bus.host_req = 1'b0;
      end
      if (!host_busy && resetN && ($urandom_range(0, 2) == 0)) begin
        host_busy      = 1;
        host_wait      = 0;
        bus.host_req   = 1'b1;
        bus.host_we    = $urandom_range(0, 1) == 1;
        bus.host_addr  = AW'($urandom_range(0, 15));
        bus.host_wdata = DW'($urandom);
      end
      bus.cpu_read_m    = ($urandom_range(0, 2) == 0);
      bus.cpu_write_m   = ($urandom_range(0, 2) == 0);
      bus.cpu_data_addr = AW'($urandom_range(0, 15));
      bus.cpu_out_m     = DW'($urandom);
      @(negedge clk);
      ack_seen = bus.host_ack;
      if (host_busy) begin
        if (ack_seen) begin
          chk("host_wait_1to2", {31'd0, (host_wait >= 1 && host_wait <= 2)}, 32'd1);
        end else begin
          host_wait++;
          if (host_wait > 6) begin
            chk("host_timeout", host_wait, 32'd0);
            host_busy    = 0;
            bus.host_req = 1'b0;
          end
        end
      end
    end

    step();
    bus.host_req    = 1'b0;
    bus.cpu_read_m  = 1'b0;
    bus.cpu_write_m = 1'b0;
    resetN          = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
